pulse_width_rx: RTL and testbench
=================================

PULSE_WIDTH_RX -- requirements
Module: pulse_width_rx

Interface
REQ-001 Parameter MSG_BITS, default 24: payload bits per frame (8..32).
REQ-002 Parameter CNT_W, default 8: width of the high-time and low-time counters.
REQ-003 Parameter THRESH, default 26: high time in cycles; a bit is 1 when high time > THRESH, otherwise 0.
REQ-004 Parameter IDLE_TICKS, default 200: low time in cycles that aborts a partial frame; must be < 2^CNT_W - 1.
REQ-005 Parameter FIFO_DEPTH, default 4: received-frame buffer depth; power of 2, >= 2.
REQ-006 clock  in  1  clock; all state is updated on its rising edge.
REQ-007 reset  in  1  reset, asynchronous, active-high.
REQ-008 neo_in  in  1  serial pulse-width-coded line, asynchronous to clock.
REQ-009 msg_ack  in  1  pop of the head frame; ignored while msg_valid=0.
REQ-010 ovf_clr  in  1  clears overflow.
REQ-011 msg_valid  out  1  FIFO non-empty.
REQ-012 msg_data  out  MSG_BITS  head frame; the first-received bit is the MSB.
REQ-013 msg_count  out  $clog2(FIFO_DEPTH)+1  number of frames held.
REQ-014 frame_error  out  1  one-cycle pulse when a frame is discarded.
REQ-015 overflow  out  1  sticky flag; a frame was dropped because the FIFO was full.

Function
REQ-016 neo_in passes through a 2-flop synchronizer; all following requirements refer to the synchronized line (sync).
REQ-017 The FSM has three states:
- IDLE: waits for sync=1, then enters HIGH.
- HIGH: the high counter counts, saturating at 2^CNT_W-1; on sync falling, the bit is decided and the FSM enters LOW.
- LOW: the low counter counts, saturating; on sync=1, the FSM enters HIGH.
REQ-018 Entering HIGH clears the high counter; entering LOW clears the low counter.
REQ-019 On each falling edge, the decided bit is shifted into the LSB of the frame shift register and the bit counter increments.
REQ-020 When the bit counter reaches frame length, the frame is pushed on that same edge and the bit counter clears.
- msg_valid (empty FIFO) rises on the following cycle.
- The FSM stays in LOW.
REQ-021 In LOW with 0 < bit count < frame length, low count reaching IDLE_TICKS does the following:
- pulses frame_error;
- clears the shift register and bit counter;
- sends the FSM to IDLE.
REQ-022 In LOW with bit count 0, low count reaching IDLE_TICKS sends the FSM to IDLE without an error.
REQ-023 A high pulse exactly THRESH cycles long decodes as 0; THRESH+1 cycles decodes as 1.
REQ-024 A push while full with no simultaneous pop drops the frame, sets overflow and leaves the FIFO unchanged.
REQ-025 A push and a pop in the same cycle while full both succeed; msg_count is unchanged and there is no overflow.
REQ-026 A push and a pop in the same cycle while empty: msg_valid rises next cycle with the new frame.
REQ-027 The FIFO read and write pointers wrap modulo FIFO_DEPTH; msg_count is the exact occupancy, 0..FIFO_DEPTH.
REQ-028 ovf_clr clears overflow next cycle; if ovf_clr coincides with a new overflow event, overflow stays set.
REQ-029 msg_data is stable while msg_valid=1 and no msg_ack occurs.

Reset
REQ-030 Reset sends the FSM to IDLE and clears the synchronizer, counters, shift register and FIFO pointers.
REQ-031 After reset: msg_valid=0, msg_data=0, msg_count=0, frame_error=0, overflow=0.
REQ-032 A reset during a frame discards the partial frame and all buffered frames, with no frame_error.

Configuration
REQ-033 With PWRX_PARITY_EN defined, the frame is MSG_BITS+1 bits and the last bit is even parity over the frame.
- On a parity match, only the MSG_BITS payload bits are pushed.
- On a mismatch, the frame is not pushed, frame_error pulses and overflow is unaffected.
REQ-034 With PWRX_PARITY_EN undefined, the frame is MSG_BITS bits, no parity is checked and frame_error comes only from REQ-021.

Verification
REQ-035 Defaults, no parity: send 24 bits 0xA5C3F0, high 40/10 cycles for 1/0, low 30 cycles -> msg_valid=1, msg_data=0xA5C3F0, msg_count=1.
REQ-036 High pulses of 26 and 27 cycles as the final two bits of a frame -> msg_data[1:0]=2'b01.
REQ-037 Send 10 bits, then hold low 200 cycles -> one frame_error pulse, FSM in IDLE; a following 24-bit frame 0x000001 is received correctly.
REQ-038 Send 5 frames with no acks (FIFO_DEPTH=4) -> msg_count=4, overflow=1, head = frame 1; ack on the cycle of the 6th push -> msg_count stays 4, no additional drop.
REQ-039 With PWRX_PARITY_EN: payload 0x000003 with parity 1 -> frame_error pulses, msg_valid stays 0; with parity 0 -> msg_data=0x000003.
REQ-040 Assert reset mid-frame after 12 bits with 2 frames buffered -> all outputs 0; the next full frame is received with msg_count=1.

Source files
------------

// File: rtl/pulse_width_rx_if.sv
// Frame-delivery port of pulse_width_rx: head frame, FIFO occupancy and pop strobe.
interface pulse_width_rx_if #(
    parameter int MSG_BITS   = 24,
    parameter int FIFO_DEPTH = 4
);
    logic                        msg_valid;
    logic                        msg_ack;
    logic [MSG_BITS-1:0]         msg_data;
    logic [$clog2(FIFO_DEPTH):0] msg_count;

    modport master (output msg_valid, output msg_data, output msg_count, input msg_ack);
    modport slave  (input msg_valid, input msg_data, input msg_count, output msg_ack);
endinterface

// File: rtl/pulse_width_rx.sv
// Pulse-width-coded serial receiver: bits decoded from high time, frames buffered in a FIFO.
// Define PWRX_PARITY_EN to receive an extra even-parity bit per frame and drop frames that fail it.
module pulse_width_rx #(
    parameter int MSG_BITS   = 24,
    parameter int CNT_W      = 8,
    parameter int THRESH     = 26,
    parameter int IDLE_TICKS = 200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             neo_in,
    input  logic             ovf_clr,
    pulse_width_rx_if.master msg,
    output logic             frame_error,
    output logic             overflow
);
`ifdef PWRX_PARITY_EN
    localparam int FRAME_LEN = MSG_BITS + 1;
`else
    localparam int FRAME_LEN = MSG_BITS;
`endif
    localparam int BC_W  = $clog2(FRAME_LEN + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    // hi_cnt misses the cycle that entered HIGH, so hi_cnt >= THRESH means high time > THRESH.
    localparam logic [CNT_W-1:0] HI_LIMIT = CNT_W'(THRESH);
    // lo_cnt misses the falling cycle and the current one, hence the -2.
    localparam logic [CNT_W-1:0] LO_LIMIT = CNT_W'(IDLE_TICKS - 2);

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

    state_t                state_q, state_d;
    logic                  sync_meta, sync;
    logic [CNT_W-1:0]      hi_cnt, lo_cnt;
    logic [BC_W-1:0]       bit_cnt;
    logic [FRAME_LEN-1:0]  shift_q, shift_nx;
    logic                  bit_done, idle_timeout, abort_err;
    logic                  bit_val, frame_done, parity_ok;
    logic [MSG_BITS-1:0]   push_data;

    logic [MSG_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [OCC_W-1:0]      count;
    logic                  full, pop, push_req, push_ok, drop;

    // NOTE: non-blocking assignments keep sync_meta and sync as two separate flop stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            sync_meta <= neo_in;
            sync      <= sync_meta;
            state_q   <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        bit_done     = 1'b0;
        idle_timeout = 1'b0;
        case (state_q)
            ST_IDLE: if (sync) state_d = ST_HIGH;
            ST_HIGH: begin
                if (!sync) begin
                    bit_done = 1'b1;
                    state_d  = ST_LOW;
                end
            end
            ST_LOW: begin
                if (sync) begin
                    state_d = ST_HIGH;
                end else if (lo_cnt == LO_LIMIT) begin
                    idle_timeout = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bit_val    = (hi_cnt >= HI_LIMIT);
    assign shift_nx   = {shift_q[FRAME_LEN-2:0], bit_val};
    assign frame_done = bit_done && (bit_cnt == BC_W'(FRAME_LEN - 1));
    assign abort_err  = idle_timeout && (bit_cnt != '0);

`ifdef PWRX_PARITY_EN
    assign parity_ok = ~(^shift_nx);
    assign push_data = shift_nx[FRAME_LEN-1:1];
`else
    assign parity_ok = 1'b1;
    assign push_data = shift_nx;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            bit_cnt     <= '0;
            shift_q     <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= abort_err || (frame_done && !parity_ok);

            if (state_q != ST_HIGH && state_d == ST_HIGH)
                hi_cnt <= '0;
            else if (state_q == ST_HIGH && sync && hi_cnt != '1)
                hi_cnt <= hi_cnt + CNT_W'(1);

            if (bit_done)
                lo_cnt <= '0;
            else if (state_q == ST_LOW && !sync && lo_cnt != '1)
                lo_cnt <= lo_cnt + CNT_W'(1);

            if (frame_done || abort_err) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end else if (bit_done) begin
                shift_q <= shift_nx;
                bit_cnt <= bit_cnt + BC_W'(1);
            end
        end
    end

    assign full     = (count == OCC_W'(FIFO_DEPTH));
    assign pop      = msg.msg_ack && msg.msg_valid;
    assign push_req = frame_done && parity_ok;
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // NOTE: the frame storage has no reset; msg_data is masked while empty instead.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
            // A new drop wins over a coincident clear.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign msg.msg_valid = (count != '0);
    assign msg.msg_count = count;
    assign msg.msg_data  = msg.msg_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_pulse_width_rx.sv
// Scoreboard bench for pulse_width_rx: a run-length line model predicts frames, a monitor pops and compares.
// Builds with or without PWRX_PARITY_EN.
module tb_pulse_width_rx;
    localparam int MSG_BITS   = 24;
    localparam int CNT_W      = 8;
    localparam int THRESH     = 26;
    localparam int IDLE_TICKS = 200;
    localparam int FIFO_DEPTH = 4;
`ifdef PWRX_PARITY_EN
    localparam int FRAME_LEN = MSG_BITS + 1;
`else
    localparam int FRAME_LEN = MSG_BITS;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic neo_in = 1'b0;
    logic ovf_clr = 1'b0;
    logic frame_error, overflow;

    pulse_width_rx_if #(.MSG_BITS(MSG_BITS), .FIFO_DEPTH(FIFO_DEPTH)) ifc ();

    pulse_width_rx #(
        .MSG_BITS(MSG_BITS), .CNT_W(CNT_W), .THRESH(THRESH),
        .IDLE_TICKS(IDLE_TICKS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .neo_in(neo_in), .ovf_clr(ovf_clr),
        .msg(ifc.master), .frame_error(frame_error), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int err_exp  = 0;
    int err_seen = 0;
    bit ovf_exp  = 1'b0;
    bit auto_ack = 1'b0;
    bit manual_ack = 1'b0;
    bit model_bits[$];
    logic [MSG_BITS-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Line model: each high run is one bit (1 when longer than THRESH); a long low aborts a partial frame.
    task automatic model_bit(input int h);
        logic [MSG_BITS-1:0] pay;
        bit bad;
        model_bits.push_back(h > THRESH);
        if (model_bits.size() == FRAME_LEN) begin
            pay = '0;
            for (int i = 0; i < MSG_BITS; i++) pay = {pay[MSG_BITS-2:0], model_bits[i]};
            bad = 1'b0;
`ifdef PWRX_PARITY_EN
            for (int i = 0; i < FRAME_LEN; i++) bad ^= model_bits[i];
`endif
            if (bad) err_exp++;
            else if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(pay);
            else ovf_exp = 1'b1;
            model_bits.delete();
        end
    endtask

    task automatic model_low(input int l);
        if (model_bits.size() > 0 && l >= IDLE_TICKS) begin
            err_exp++;
            model_bits.delete();
        end
    endtask

    function automatic int rand_high(input bit b);
        return b ? int'($urandom_range(60, THRESH + 1)) : int'($urandom_range(THRESH, 1));
    endfunction

    // High for h cycles then low for l; ack_at_fall pops in the very cycle the DUT pushes this bit's frame.
    task automatic send_pulse(input int h, input int l, input bit ack_at_fall);
        neo_in = 1'b1;
        cycles(h);
        neo_in = 1'b0;
        if (ack_at_fall) begin
            cycles(2);
            manual_ack = 1'b1;
            cycles(1);
            manual_ack = 1'b0;
            model_bit(h);
            cycles(l - 3);
        end else begin
            model_bit(h);
            cycles(l);
        end
        model_low(l);
    endtask

    task automatic send_frame(input logic [MSG_BITS-1:0] payload, input bit fixed, input int last_low,
                              input bit ack_last, input bit flip_par, input int gap_idx, input int gap_len);
        logic [MSG_BITS:0] w;
        int lo_idx, k, h, l;
        w = {payload, (^payload) ^ flip_par};
        lo_idx = MSG_BITS + 1 - FRAME_LEN;
        k = 0;
        for (int i = MSG_BITS; i >= lo_idx; i--) begin
            h = fixed ? (w[i] ? 40 : 10) : rand_high(w[i]);
            if (i == lo_idx)      l = last_low;
            else if (k == gap_idx) l = gap_len;
            else                  l = fixed ? 30 : int'($urandom_range(40, 1));
            send_pulse(h, l, ack_last && (i == lo_idx));
            k++;
        end
    endtask

    task automatic wait_drain();
        int t;
        auto_ack = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || ifc.msg_valid) && t < 300) begin
            cycles(1);
            t++;
        end
        check("drain_in_time", t < 300, 1);
        check("drained_count", ifc.msg_count, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_bits.delete();
        exp_q.delete();
        ovf_exp = 1'b0;
        cycles(2);
    endtask

    // Monitor: whenever a frame is presented and acking is enabled, compare the head and pop it.
    initial begin
        ifc.msg_ack = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && ifc.msg_valid && (auto_ack || manual_ack)) begin
                check("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("frame_data", ifc.msg_data, exp_q.pop_front());
                ifc.msg_ack = 1'b1;
            end else begin
                ifc.msg_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (frame_error === 1'b1) err_seen++;
        end
    end

    initial begin
        logic [MSG_BITS-1:0] f[6];
        logic [MSG_BITS-1:0] p;
        int e0;

        #1;
        do_reset();
        cycles(1);
        reset = 1'b0;
        cycles(2);
        check("rst_valid", ifc.msg_valid, 0);
        check("rst_data", ifc.msg_data, 0);
        check("rst_count", ifc.msg_count, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_overflow", overflow, 0);

        // Fixed-timing frame, held in the FIFO until inspected.
        send_frame(24'hA5C3F0, 1'b1, 30, 1'b0, 1'b0, -1, 0);
        check("fixed_valid", ifc.msg_valid, 1);
        check("fixed_count", ifc.msg_count, 1);
        check("fixed_data", ifc.msg_data, 24'hA5C3F0);
        wait_drain();

        // Threshold boundary: THRESH cycles -> 0, THRESH+1 cycles -> 1.
        auto_ack = 1'b0;
        p = {22'($urandom), 2'b01};
        for (int i = MSG_BITS - 1; i >= 2; i--) send_pulse(rand_high(p[i]), 20, 1'b0);
        send_pulse(THRESH, 20, 1'b0);
        send_pulse(THRESH + 1, (FRAME_LEN > MSG_BITS) ? 20 : 30, 1'b0);
        if (FRAME_LEN > MSG_BITS) send_pulse(rand_high(^p), 30, 1'b0);
        check("thresh_count", ifc.msg_count, 1);
        check("thresh_low_bits", ifc.msg_data[1:0], 2'b01);
        check("thresh_data", ifc.msg_data, p);
        wait_drain();

        // Partial frame aborted by a long low, then clean frames including a gap one short of the limit.
        e0 = err_seen;
        for (int i = 0; i < 10; i++)
            send_pulse(rand_high(1'($urandom)), (i == 9) ? IDLE_TICKS : int'($urandom_range(40, 1)), 1'b0);
        cycles(5);
        check("abort_error_pulses", err_seen - e0, 1);
        check("abort_no_frame", ifc.msg_valid, 0);
        send_frame(24'h000001, 1'b0, 30, 1'b0, 1'b0, -1, 0);
        send_frame(24'($urandom), 1'b0, 30, 1'b0, 1'b0, 9, IDLE_TICKS - 1);
        wait_drain();
        check("gap_no_error", err_seen - e0, 1);

        // Fill past capacity, clear overflow, then push and pop in the same cycle while full.
        auto_ack = 1'b0;
        for (int i = 0; i < 6; i++) f[i] = 24'($urandom);
        for (int i = 0; i < 5; i++) send_frame(f[i], 1'b0, 20, 1'b0, 1'b0, -1, 0);
        check("full_count", ifc.msg_count, FIFO_DEPTH);
        check("full_overflow", overflow, ovf_exp);
        check("full_head", ifc.msg_data, f[0]);
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        ovf_exp = 1'b0;
        cycles(1);
        check("ovf_cleared", overflow, 0);
        send_frame(f[5], 1'b0, 20, 1'b1, 1'b0, -1, 0);
        check("pushpop_count", ifc.msg_count, FIFO_DEPTH);
        check("pushpop_no_overflow", overflow, 0);
        check("pushpop_head", ifc.msg_data, f[1]);
        wait_drain();

`ifdef PWRX_PARITY_EN
        auto_ack = 1'b0;
        e0 = err_seen;
        send_frame(24'h000003, 1'b0, 30, 1'b0, 1'b1, -1, 0);
        cycles(2);
        check("parity_bad_error", err_seen - e0, 1);
        check("parity_bad_valid", ifc.msg_valid, 0);
        check("parity_bad_overflow", overflow, 0);
        send_frame(24'h000003, 1'b0, 30, 1'b0, 1'b0, -1, 0);
        check("parity_good_data", ifc.msg_data, 24'h000003);
        wait_drain();
`endif

        // Reset in the middle of a frame with two frames buffered.
        auto_ack = 1'b0;
        e0 = err_seen;
        for (int i = 0; i < 2; i++) send_frame(24'($urandom), 1'b0, 20, 1'b0, 1'b0, -1, 0);
        check("pre_reset_count", ifc.msg_count, 2);
        for (int i = 0; i < 12; i++) send_pulse(rand_high(1'($urandom)), int'($urandom_range(40, 1)), 1'b0);
        do_reset();
        check("mid_rst_valid", ifc.msg_valid, 0);
        check("mid_rst_data", ifc.msg_data, 0);
        check("mid_rst_count", ifc.msg_count, 0);
        check("mid_rst_overflow", overflow, 0);
        reset = 1'b0;
        cycles(2);
        p = 24'($urandom);
        send_frame(p, 1'b0, 30, 1'b0, 1'b0, -1, 0);
        check("post_rst_count", ifc.msg_count, 1);
        check("post_rst_data", ifc.msg_data, p);
        check("rst_no_error", err_seen - e0, 0);
        wait_drain();

        // Random frames, random idle gaps and random aborted partial frames.
        for (int n = 0; n < 8; n++) begin
            send_frame(24'($urandom), 1'b0, int'($urandom_range(250, 3)), 1'b0, 1'b0, -1, 0);
            if (n % 3 == 1) begin
                int nb;
                nb = int'($urandom_range(FRAME_LEN - 1, 1));
                for (int i = 0; i < nb; i++)
                    send_pulse(rand_high(1'($urandom)),
                               (i == nb - 1) ? IDLE_TICKS + int'($urandom_range(30, 0)) : int'($urandom_range(40, 1)),
                               1'b0);
            end
        end
        wait_drain();
        cycles(5);
        check("frame_error_total", err_seen, err_exp);
        check("final_overflow", overflow, ovf_exp);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
